// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state encoding, block/length geometry and
// the IV and round-constant tables used by the compression core.
package sha256_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BLOCK_W       = 512;
    localparam int unsigned LEN_FIELD_W   = 64;
    localparam int unsigned WORDS_PER_BLK = BLOCK_W / WORD_W;
    localparam int unsigned LEN_FIT_BYTES = (BLOCK_W - LEN_FIELD_W) / 8;

    localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SEND   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LENBLK = 3'd4
    } pad_state_e;

    localparam logic [WORD_W-1:0] SHA_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [WORD_W-1:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_pad_word.sv
// Keeps the first i_bytes bytes of a big-endian word, zeroes the rest and,
// when i_pad is set, drops the 0x80 marker into the first byte after the data.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [2:0]        i_bytes,
    input  logic              i_pad,
    output logic [WORD_W-1:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < i_bytes) begin
                o_word[WORD_W-1-8*b -: 8] = i_word[WORD_W-1-8*b -: 8];
            end else if (3'(b) == i_bytes && i_pad) begin
                o_word[WORD_W-1-8*b -: 8] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks, appends the
// 0x80 marker and 64-bit bit length, and hands blocks to the compression core.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [WORD_W-1:0]    i_Data,
    input  logic                 i_Valid,
    input  logic                 i_Last,
    input  logic [2:0]           i_Bytes,
    output logic                 o_Ready,
    output logic [BLOCK_W-1:0]   o_Block,
    output logic                 o_fStart,
    output logic                 o_fFirst,
    output logic                 o_fLastBlk,
    input  logic                 i_fDone
);

    pad_state_e             state_q, state_d;
    logic [BLOCK_W-1:0]     block_q, block_d;
    logic [3:0]             widx_q, widx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   last_q, last_d;
    logic                   pad_q, pad_d;
    logic                   lenblk_q, lenblk_d;
    logic                   first_q, first_d;
    logic                   fstart_q, fstart_d;
    logic                   ffirst_q, ffirst_d;
    logic                   flastblk_q, flastblk_d;

    logic                   ready_c;
    logic                   accept_c;
    logic [2:0]             eff_bytes;
    logic [WORD_W-1:0]      pad_word;
    logic [LEN_W-1:0]       len_next;
    logic [LEN_FIELD_W-1:0] len_field;
    logic [6:0]             b_used;
    logic                   len_fits;
    logic [BLOCK_W-1:0]     fill_block;
    logic [BLOCK_W-1:0]     fin_block;
    logic [BLOCK_W-1:0]     len_block;

    assign ready_c   = (state_q == ST_IDLE) ||
                       (state_q == ST_FILL && !last_q);
    assign accept_c  = i_Valid && ready_c;
    assign eff_bytes = (!i_Last || i_Bytes > 3'd4) ? 3'd4 : i_Bytes;
    assign len_next  = len_q + LEN_W'({eff_bytes, 3'b000});
    assign len_field = LEN_FIELD_W'(len_next);
    // Bytes of this block in use once the marker lands right after the data.
    assign b_used    = 7'({widx_q, 2'b00}) + 7'(eff_bytes) + 7'd1;
    assign len_fits  = (b_used <= 7'(LEN_FIT_BYTES));

    sha256_pad_word u_pad_word (
        .i_word  (i_Data),
        .i_bytes (eff_bytes),
        .i_pad   (i_Last),
        .o_word  (pad_word)
    );

    // Candidate block contents: mid-block write, final padded block, length-only block.
    always_comb begin
        fill_block = block_q;
        fin_block  = '0;
        for (int j = 0; j < int'(WORDS_PER_BLK); j++) begin
            if (j == int'(widx_q)) begin
                fill_block[BLOCK_W-1-WORD_W*j -: WORD_W] = pad_word;
            end
            if (j < int'(widx_q)) begin
                fin_block[BLOCK_W-1-WORD_W*j -: WORD_W] = block_q[BLOCK_W-1-WORD_W*j -: WORD_W];
            end else if (j == int'(widx_q)) begin
                fin_block[BLOCK_W-1-WORD_W*j -: WORD_W] = pad_word;
            end else if (j == int'(widx_q) + 1 && eff_bytes == 3'd4) begin
                fin_block[BLOCK_W-1-WORD_W*j -: WORD_W] = PAD_WORD;
            end
        end
        if (len_fits) begin
            fin_block[LEN_FIELD_W-1:0] = len_field;
        end
        len_block = '0;
        if (!pad_q) begin
            len_block[BLOCK_W-1 -: WORD_W] = PAD_WORD;
        end
        len_block[LEN_FIELD_W-1:0] = LEN_FIELD_W'(len_q);
    end

    always_comb begin
        state_d    = state_q;
        block_d    = block_q;
        widx_d     = widx_q;
        len_d      = len_q;
        last_d     = last_q;
        pad_d      = pad_q;
        lenblk_d   = lenblk_q;
        first_d    = first_q;
        fstart_d   = 1'b0;
        ffirst_d   = 1'b0;
        flastblk_d = flastblk_q;

        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept_c) begin
                    len_d = len_next;
                    if (i_Last) begin
                        block_d    = fin_block;
                        last_d     = 1'b1;
                        pad_d      = (b_used <= 7'd64);
                        lenblk_d   = !len_fits;
                        state_d    = ST_SEND;
                        fstart_d   = 1'b1;
                        ffirst_d   = first_q;
                        first_d    = 1'b0;
                        flastblk_d = len_fits;
                    end else begin
                        block_d = fill_block;
                        widx_d  = widx_q + 4'd1;
                        state_d = ST_FILL;
                        // The 16th word closes a raw data block.
                        if (widx_q == 4'(WORDS_PER_BLK - 1)) begin
                            state_d    = ST_SEND;
                            fstart_d   = 1'b1;
                            ffirst_d   = first_q;
                            first_d    = 1'b0;
                            flastblk_d = 1'b0;
                        end
                    end
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_fDone) begin
                    flastblk_d = 1'b0;
                    if (lenblk_q) begin
                        state_d = ST_LENBLK;
                    end else if (last_q) begin
                        state_d  = ST_IDLE;
                        widx_d   = '0;
                        len_d    = '0;
                        last_d   = 1'b0;
                        pad_d    = 1'b0;
                        first_d  = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                        widx_d  = '0;
                    end
                end
            end
            ST_LENBLK: begin
                block_d    = len_block;
                lenblk_d   = 1'b0;
                state_d    = ST_SEND;
                fstart_d   = 1'b1;
                ffirst_d   = first_q;
                first_d    = 1'b0;
                flastblk_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            block_q    <= '0;
            widx_q     <= '0;
            len_q      <= '0;
            last_q     <= 1'b0;
            pad_q      <= 1'b0;
            lenblk_q   <= 1'b0;
            first_q    <= 1'b1;
            fstart_q   <= 1'b0;
            ffirst_q   <= 1'b0;
            flastblk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            block_q    <= block_d;
            widx_q     <= widx_d;
            len_q      <= len_d;
            last_q     <= last_d;
            pad_q      <= pad_d;
            lenblk_q   <= lenblk_d;
            first_q    <= first_d;
            fstart_q   <= fstart_d;
            ffirst_q   <= ffirst_d;
            flastblk_q <= flastblk_d;
        end
    end

    assign o_Ready    = ready_c;
    assign o_Block    = block_q;
    assign o_fStart   = fstart_q;
    assign o_fFirst   = ffirst_q;
    assign o_fLastBlk = flastblk_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed vectors plus random messages checked
// against a byte-level model of standard SHA-256 message padding.
module tb_sha256_padder;

    logic         i_Clk;
    logic         i_Rst;
    logic [31:0]  i_Data;
    logic         i_Valid;
    logic         i_Last;
    logic [2:0]   i_Bytes;
    logic         o_Ready;
    logic [511:0] o_Block;
    logic         o_fStart;
    logic         o_fFirst;
    logic         o_fLastBlk;
    logic         i_fDone;

    sha256_padder #(.LEN_W(64)) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Data     (i_Data),
        .i_Valid    (i_Valid),
        .i_Last     (i_Last),
        .i_Bytes    (i_Bytes),
        .o_Ready    (o_Ready),
        .o_Block    (o_Block),
        .o_fStart   (o_fStart),
        .o_fFirst   (o_fFirst),
        .o_fLastBlk (o_fLastBlk),
        .i_fDone    (i_fDone)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [511:0] blk;
        bit           first;
        bit           last;
    } exp_t;

    typedef struct {
        int          nbytes;
        bit          extra;
        int          gap;
        int          dly;
        int          exp_blocks;
        logic [31:0] exp_w0;
        logic [31:0] exp_w15;
    } vec_t;

    int           checks;
    int           failures;
    logic [7:0]   cur_msg[$];
    exp_t         exp_q[$];
    int           blocks_seen;
    logic [511:0] last_blk;
    logic         first_flag;

    localparam logic [511:0] ABC_BLK = {32'h61626380, {13{32'h0}}, 32'h0, 32'h18};

    task automatic chk_eq(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic set_msg(input int n, input bit directed);
        cur_msg.delete();
        for (int i = 0; i < n; i++) begin
            if (directed) cur_msg.push_back(8'h61 + 8'(i % 26));
            else          cur_msg.push_back(8'($urandom()));
        end
    endtask

    // Standard SHA-256 padding on a byte list, then cut into 64-byte blocks.
    function automatic void build_expected();
        logic [7:0]  p[$];
        logic [63:0] bl;
        int          nb;
        exp_t        e;
        exp_q.delete();
        p = cur_msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(cur_msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[64*b+i];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic drive(input int gap, input bit extra);
        int          n, nw, nb, cnt;
        bit          last;
        logic [31:0] d;
        n  = cur_msg.size();
        nw = (n + 3) / 4;
        if (n == 0 || (extra && n % 4 == 0)) nw++;
        for (int w = 0; w < nw; w++) begin
            last = (w == nw - 1);
            nb = n - 4 * w;
            if (nb > 4) nb = 4;
            if (nb < 0) nb = 0;
            d = $urandom();
            for (int b = 0; b < nb; b++) d[31-8*b -: 8] = cur_msg[4*w+b];
            while ($urandom_range(0, 99) < gap) begin
                i_Valid = 1'b0;
                i_Data  = $urandom();
                i_Last  = 1'($urandom_range(0, 1));
                @(negedge i_Clk);
            end
            i_Valid = 1'b1;
            i_Data  = d;
            i_Last  = last;
            i_Bytes = last ? 3'(nb) : 3'($urandom_range(0, 4));
            cnt = 0;
            while (!o_Ready && cnt < 2000) begin
                @(negedge i_Clk);
                cnt++;
            end
            if (!o_Ready) begin
                fail_now("drive_ready");
                break;
            end
            @(negedge i_Clk);
            if (last || w % 16 == 15) chk_eq("start_latency", o_fStart, 1'b1);
        end
        i_Valid = 1'b0;
        i_Last  = 1'b0;
    endtask

    task automatic respond(input int dly, input bit spur);
        int           cnt;
        logic [511:0] cap;
        bit           held;
        for (int k = 0; k < exp_q.size(); k++) begin
            cnt = 0;
            while (!o_fStart && cnt < 3000) begin
                @(negedge i_Clk);
                cnt++;
            end
            if (!o_fStart) begin
                fail_now("start_wait");
                return;
            end
            cap = o_Block;
            chk_eq("block", o_Block, exp_q[k].blk);
            chk_eq("flags_first_last", {o_fFirst, o_fLastBlk}, {exp_q[k].first, exp_q[k].last});
            if (k == 0) first_flag = o_fFirst;
            blocks_seen++;
            last_blk = cap;
            if (spur) i_fDone = 1'b1;
            @(negedge i_Clk);
            i_fDone = 1'b0;
            held = 1'b1;
            for (int d = 0; d <= dly; d++) begin
                if (o_Block !== cap || o_fStart !== 1'b0 || o_Ready !== 1'b0 ||
                    o_fLastBlk !== exp_q[k].last) held = 1'b0;
                if (d < dly) @(negedge i_Clk);
            end
            chk_eq("hold_in_wait", held, 1'b1);
            i_fDone = 1'b1;
            @(negedge i_Clk);
            i_fDone = 1'b0;
        end
    endtask

    task automatic run_msg(input int gap, input int dly, input bit extra, input bit spur);
        build_expected();
        blocks_seen = 0;
        fork
            drive(gap, extra);
            respond(dly, spur);
        join
        chk_eq("block_count", blocks_seen, exp_q.size());
        chk_eq("idle_after_msg", {o_Ready, o_fLastBlk, o_fStart}, 3'b100);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{3,  1'b0, 0,  0, 1, 32'h61626380, 32'h00000018};
        vecs[1] = '{0,  1'b0, 0,  1, 1, 32'h80000000, 32'h00000000};
        vecs[2] = '{55, 1'b0, 20, 2, 1, 32'h61626364, 32'h000001b8};
        vecs[3] = '{56, 1'b0, 0,  3, 2, 32'h00000000, 32'h000001c0};
        vecs[4] = '{64, 1'b0, 30, 0, 2, 32'h80000000, 32'h00000200};
        vecs[5] = '{64, 1'b1, 0,  2, 2, 32'h80000000, 32'h00000200};
        vecs[6] = '{52, 1'b0, 10, 1, 1, 32'h61626364, 32'h000001a0};

        checks = 0;
        failures = 0;
        i_Rst = 1'b1;
        i_Valid = 1'b0;
        i_Data = '0;
        i_Last = 1'b0;
        i_Bytes = '0;
        i_fDone = 1'b0;
        repeat (3) @(negedge i_Clk);
        chk_eq("reset_ready", o_Ready, 1'b1);
        chk_eq("reset_block", o_Block, '0);
        chk_eq("reset_flags", {o_fStart, o_fFirst, o_fLastBlk}, 3'b000);
        i_Rst = 1'b0;
        @(negedge i_Clk);

        for (int i = 0; i < 7; i++) begin
            set_msg(vecs[i].nbytes, 1'b1);
            run_msg(vecs[i].gap, vecs[i].dly, vecs[i].extra, 1'(i % 2));
            chk_eq($sformatf("vec%0d_blocks", i), blocks_seen, vecs[i].exp_blocks);
            chk_eq($sformatf("vec%0d_last_w0", i), last_blk[511:480], vecs[i].exp_w0);
            chk_eq($sformatf("vec%0d_last_w15", i), last_blk[31:0], vecs[i].exp_w15);
        end

        // Abort a message after 7 words, then "abc" must come out clean.
        for (int w = 0; w < 7; w++) begin
            i_Valid = 1'b1;
            i_Data  = 32'h11111111 * 32'(w + 1);
            i_Last  = 1'b0;
            i_Bytes = 3'd4;
            @(negedge i_Clk);
        end
        i_Valid = 1'b0;
        i_Rst = 1'b1;
        @(negedge i_Clk);
        i_Rst = 1'b0;
        chk_eq("midrst_ready", o_Ready, 1'b1);
        chk_eq("midrst_block", o_Block, '0);
        chk_eq("midrst_flags", {o_fStart, o_fFirst, o_fLastBlk}, 3'b000);
        set_msg(3, 1'b1);
        run_msg(0, 1, 1'b0, 1'b0);
        chk_eq("abc_after_rst_block", last_blk, ABC_BLK);
        chk_eq("abc_after_rst_first", first_flag, 1'b1);

        // Slow core with bursty input.
        set_msg(100, 1'b0);
        run_msg(40, 70, 1'b0, 1'b1);

        for (int r = 0; r < 25; r++) begin
            set_msg($urandom_range(0, 140), 1'b0);
            run_msg($urandom_range(0, 60), $urandom_range(0, 6),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 64, meaning message bit-length counter width; the counter SHALL be zero-extended into the 64-bit length field.
REQ-002 SHALL have port i_Clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_Rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_Data  input  32  message word, big-endian (first byte in [31:24]).
REQ-005 SHALL have port i_Valid  input  1  i_Data is valid this cycle.
REQ-006 SHALL have port i_Last  input  1  this word ends the message.
REQ-007 SHALL have port i_Bytes  input  3  valid bytes in the word when i_Last=1 (0..4, left-aligned); 4 is implied when i_Last=0.
REQ-008 SHALL have port o_Ready  output  1  a word is accepted when i_Valid & o_Ready.
REQ-009 SHALL have port o_Block  output  512  padded block; word 0 is in [511:480].
REQ-010 SHALL have port o_fStart  output  1  one-cycle start pulse to the compression core.
REQ-011 SHALL have port o_fFirst  output  1  asserted with o_fStart on a message's first block.
REQ-012 SHALL have port o_fLastBlk  output  1  held from o_fStart until i_fDone while the final block of a message is being processed.
REQ-013 SHALL have port i_fDone  input  1  one-cycle done pulse from the compression core.

Function
REQ-014 SHALL use states IDLE, FILL, SEND, WAIT, LENBLK.
  - IDLE→FILL on the first accepted word.
  - FILL→SEND when 16 words are buffered or padding is complete.
  - SEND→WAIT after one cycle.
  - WAIT→FILL / LENBLK / IDLE on i_fDone.
  - LENBLK→SEND after one cycle.
REQ-015 SHALL assert o_Ready only in IDLE, and in FILL while fewer than 16 words are held and i_Last has not been accepted.
REQ-016 SHALL pack accepted words into the block buffer at word index 0..15 in arrival order; no bubbles are required between accepted words.
REQ-017 SHALL zero the unused bytes of the last word and insert 0x80 at the first byte position after the message; if that position is past the block end, 0x80 SHALL be placed at byte 0 of the next block.
REQ-018 SHALL let B be the number of block bytes used, including 0x80:
  - B<=56: zero-fill and write the bit length to words 14-15 (big-endian, 64 bits) in the same block.
  - otherwise: zero-fill and send, then issue a LENBLK block (zeros, 0x80 if not yet placed, length in words 14-15).
REQ-019 SHALL accumulate length in bits as sum of bytes×8, modulo 2^LEN_W.
REQ-020 SHALL pulse o_fStart exactly one cycle in SEND and hold o_Block stable from SEND until i_fDone.
REQ-021 SHALL assert o_fFirst only with the first o_fStart after IDLE.
REQ-022 SHALL ignore i_Valid when o_Ready=0 and ignore i_fDone outside WAIT.
REQ-023 SHALL treat i_Last with i_Bytes=0 as contributing no bytes; as the first word, this produces the empty-message block.
REQ-024 SHALL clear the length counter and word index on return to IDLE; a new message may begin the cycle after.
REQ-025 SHALL require a latency of 1 cycle from the final-word accept (or the 16th word) to o_fStart.

Reset
REQ-026 SHALL, when i_Rst=1 at a clock edge, force state IDLE, o_Block=0, o_fStart=0, o_fFirst=0, o_fLastBlk=0, and clear the length and word index; o_Ready SHALL then read 1.
REQ-027 SHALL discard any partial message on mid-operation reset; the core reset is owned by the system.

Structure
REQ-028 SHALL place the state encoding, block width (512), length-field width (64), IV and round-constant table in shared package sha256_pkg, which the core also uses.
REQ-029 SHALL implement byte masking and 0x80 insertion of one word in combinational sub-module sha256_pad_word.

Verification
REQ-030 SHALL test "abc" (one word 0x61626300, i_Bytes=3, last) → one block 61626380,0×13,00000000,00000018; o_fFirst=1, o_fLastBlk=1.
REQ-031 SHALL test the empty message → block 80000000,0×14,00000000; o_fFirst=1.
REQ-032 SHALL test a 55-byte message → one block with 0x80 at byte 55 and length 0x1B8; a 56-byte message → two blocks, second all-zero except length 0x1C0.
REQ-033 SHALL test a 64-byte message → first block raw data with o_fLastBlk=0; second block 80000000,…, length 0x200, o_fFirst=0, o_fLastBlk=1.
REQ-034 SHALL test random i_Valid gaps and a delayed i_fDone (64+ cycles) → o_Block unchanged through WAIT, no word lost, o_Ready=0 while full.
REQ-035 SHALL test i_Rst pulsed after 7 words of a message → IDLE, o_Ready=1; the next message "abc" yields REQ-030 output with o_fFirst=1.
